// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file definitions used by the register file and its write arbiter.
package lapido_rf_defs;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 2 ** ADDR_W;
    localparam int CNT_W  = 2;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    function automatic src_e other_src(input src_e s);
        return (s == SRC_ALU) ? SRC_MEM : SRC_ALU;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback requesters, issue/read hazard lookups and register-file write port.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = lapido_rf_defs::DATA_W,
    parameter int ADDR_W = lapido_rf_defs::ADDR_W
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              iss_valid;
    logic              iss_ready;
    logic [ADDR_W-1:0] iss_rd;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic              rs_busy;
    logic              rt_busy;
    logic              rf_en;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_data;
    logic              sb_err;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output iss_valid, iss_rd, rs, rt,
        input  alu_ready, mem_ready, iss_ready, rs_busy, rt_busy,
        input  rf_en, rf_rd, rf_data, sb_err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  iss_valid, iss_rd, rs, rt,
        output alu_ready, mem_ready, iss_ready, rs_busy, rt_busy,
        output rf_en, rf_rd, rf_data, sb_err
    );

endinterface

// File: rtl/regfile_write_arbiter_scoreboard.sv
// Per-register pending-write counters: issue increments, register-file write decrements.
module regfile_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              iss_ready,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              rs_busy,
    output logic              rt_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_rd,
    output logic              sb_err
);
    localparam int                N_ENTRIES = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] RD_ZERO   = {ADDR_W{1'b0}};

    logic [CNT_W-1:0]     cnt_r [N_ENTRIES];
    logic [N_ENTRIES-1:0] inc_vec_s;
    logic [N_ENTRIES-1:0] dec_vec_s;
    logic                 inc_s;
    logic                 dec_s;
    logic                 underflow_s;
    logic                 sb_err_r;

    // Saturation gate for issue, and qualified inc/dec strobes (register 0 is never tracked)
    always_comb begin
        iss_ready = (cnt_r[iss_rd] != CNT_MAX);
        inc_s     = iss_valid & iss_ready & (iss_rd != RD_ZERO);
        dec_s     = wr_en & (wr_rd != RD_ZERO);
    end

    // One-hot decode of the increment and decrement targets
    always_comb begin
        inc_vec_s = {N_ENTRIES{1'b0}};
        dec_vec_s = {N_ENTRIES{1'b0}};
        if (inc_s) begin
            inc_vec_s[iss_rd] = 1'b1;
        end else begin
            inc_vec_s[iss_rd] = 1'b0;
        end
        if (dec_s) begin
            dec_vec_s[wr_rd] = 1'b1;
        end else begin
            dec_vec_s[wr_rd] = 1'b0;
        end
    end

    // A lone decrement of an idle counter is an underflow
    always_comb begin
        underflow_s = dec_s & ~inc_vec_s[wr_rd] & (cnt_r[wr_rd] == CNT_ZERO);
        rs_busy     = (rs != RD_ZERO) & (cnt_r[rs] != CNT_ZERO);
        rt_busy     = (rt != RD_ZERO) & (cnt_r[rt] != CNT_ZERO);
        sb_err      = sb_err_r;
    end

    // Counter array and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            sb_err_r <= 1'b0;
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                case ({inc_vec_s[i], dec_vec_s[i]})
                    2'b10:   cnt_r[i] <= cnt_r[i] + CNT_ONE;
                    2'b01:   cnt_r[i] <= (cnt_r[i] == CNT_ZERO) ? CNT_ZERO : cnt_r[i] - CNT_ONE;
                    default: cnt_r[i] <= cnt_r[i];
                endcase
            end
            if (underflow_s) begin
                sb_err_r <= 1'b1;
            end else begin
                sb_err_r <= sb_err_r;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback, plus hazard scoreboard.
module regfile_write_arbiter #(
    parameter int DATA_W = lapido_rf_defs::DATA_W,
    parameter int ADDR_W = lapido_rf_defs::ADDR_W,
    parameter int CNT_W  = lapido_rf_defs::CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_write_arbiter_if.slave bus
);
    import lapido_rf_defs::*;

    src_e              pri_r;
    logic              alu_grant_s;
    logic              mem_grant_s;
    logic              contend_s;
    logic              accept_s;
    logic [ADDR_W-1:0] sel_rd_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              rf_en_r;
    logic [ADDR_W-1:0] rf_rd_r;
    logic [DATA_W-1:0] rf_data_r;
    logic              iss_ready_s;
    logic              rs_busy_s;
    logic              rt_busy_s;
    logic              sb_err_s;

    // Grant: a lone requester wins outright, contention is settled by pri_r
    always_comb begin
        alu_grant_s = 1'b0;
        mem_grant_s = 1'b0;
        contend_s   = bus.alu_valid & bus.mem_valid;
        if (contend_s) begin
            if (pri_r == SRC_MEM) begin
                mem_grant_s = 1'b1;
            end else begin
                alu_grant_s = 1'b1;
            end
        end else if (bus.alu_valid) begin
            alu_grant_s = 1'b1;
        end else if (bus.mem_valid) begin
            mem_grant_s = 1'b1;
        end else begin
            alu_grant_s = 1'b0;
            mem_grant_s = 1'b0;
        end
    end

    // Select the winning request's destination and data
    always_comb begin
        accept_s = alu_grant_s | mem_grant_s;
        if (mem_grant_s) begin
            sel_rd_s   = bus.mem_rd;
            sel_data_s = bus.mem_data;
        end else begin
            sel_rd_s   = bus.alu_rd;
            sel_data_s = bus.alu_data;
        end
    end

    // Write stage register and round-robin priority; r0 writes complete but are not issued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pri_r     <= SRC_ALU;
            rf_en_r   <= 1'b0;
            rf_rd_r   <= {ADDR_W{1'b0}};
            rf_data_r <= {DATA_W{1'b0}};
        end else begin
            if (contend_s) begin
                pri_r <= other_src(pri_r);
            end else begin
                pri_r <= pri_r;
            end
            if (accept_s) begin
                rf_en_r   <= (sel_rd_s != {ADDR_W{1'b0}});
                rf_rd_r   <= sel_rd_s;
                rf_data_r <= sel_data_s;
            end else begin
                rf_en_r   <= 1'b0;
                rf_rd_r   <= rf_rd_r;
                rf_data_r <= rf_data_r;
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (bus.iss_valid),
        .iss_rd    (bus.iss_rd),
        .iss_ready (iss_ready_s),
        .rs        (bus.rs),
        .rt        (bus.rt),
        .rs_busy   (rs_busy_s),
        .rt_busy   (rt_busy_s),
        .wr_en     (rf_en_r),
        .wr_rd     (rf_rd_r),
        .sb_err    (sb_err_s)
    );

    assign bus.alu_ready = alu_grant_s;
    assign bus.mem_ready = mem_grant_s;
    assign bus.iss_ready = iss_ready_s;
    assign bus.rs_busy   = rs_busy_s;
    assign bus.rt_busy   = rt_busy_s;
    assign bus.rf_en     = rf_en_r;
    assign bus.rf_rd     = rf_rd_r;
    assign bus.rf_data   = rf_data_r;
    assign bus.sb_err    = sb_err_s;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed scenarios followed by random traffic.
module tb_regfile_write_arbiter;
    import lapido_rf_defs::*;

    localparam int MAXC = (2 ** CNT_W) - 1;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    // reference model state
    int   cnt_m [NREGS];
    bit   err_m;
    bit   pri_m;
    bit   ga_m;
    bit   gm_m;
    wr_t  exp_q [$];

    regfile_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_write_arbiter #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare outputs against the model, then advance the model across the coming edge
    always @(negedge clk) begin
        bit ga, gm, iss_ok, inc, have_dec;
        logic [ADDR_W-1:0] rd_sel;
        logic [DATA_W-1:0] data_sel;
        wr_t e, n;
        if (!rst) begin
            chk("rst_rf_en", bus.rf_en, 1'b0);
            chk("rst_rs_busy", bus.rs_busy, 1'b0);
            chk("rst_rt_busy", bus.rt_busy, 1'b0);
            chk("rst_sb_err", bus.sb_err, 1'b0);
            chk("rst_iss_ready", bus.iss_ready, 1'b1);
            for (int i = 0; i < NREGS; i++) cnt_m[i] = 0;
            err_m = 1'b0;
            pri_m = 1'b0;
            ga_m  = 1'b0;
            gm_m  = 1'b0;
            exp_q.delete();
        end else begin
            ga = bus.alu_valid && (!bus.mem_valid || !pri_m);
            gm = bus.mem_valid && (!bus.alu_valid || pri_m);
            chk("alu_ready", bus.alu_ready, ga);
            chk("mem_ready", bus.mem_ready, gm);
            iss_ok = (cnt_m[bus.iss_rd] < MAXC);
            chk("iss_ready", bus.iss_ready, iss_ok);
            chk("rs_busy", bus.rs_busy, (bus.rs != 0) && (cnt_m[bus.rs] != 0));
            chk("rt_busy", bus.rt_busy, (bus.rt != 0) && (cnt_m[bus.rt] != 0));
            chk("sb_err", bus.sb_err, err_m);

            have_dec = 1'b0;
            if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                have_dec = 1'b1;
                chk("rf_en", bus.rf_en, 1'b1);
                chk("rf_rd", bus.rf_rd, e.rd);
                chk("rf_data", bus.rf_data, e.data);
            end else begin
                chk("rf_en_idle", bus.rf_en, 1'b0);
            end

            inc = bus.iss_valid && iss_ok && (bus.iss_rd != 0);
            if (!(inc && have_dec && bus.iss_rd == e.rd)) begin
                if (inc) cnt_m[bus.iss_rd]++;
                if (have_dec) begin
                    if (cnt_m[e.rd] == 0) err_m = 1'b1;
                    else cnt_m[e.rd]--;
                end
            end

            if (ga || gm) begin
                rd_sel   = ga ? bus.alu_rd : bus.mem_rd;
                data_sel = ga ? bus.alu_data : bus.mem_data;
                if (rd_sel != 0) begin
                    n.cyc  = cyc + 1;
                    n.rd   = rd_sel;
                    n.data = data_sel;
                    exp_q.push_back(n);
                end
            end
            if (bus.alu_valid && bus.mem_valid) pri_m = !pri_m;
            ga_m = ga;
            gm_m = gm;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        bus.iss_valid = 1'b0;
    endtask

    task automatic issue_once(input logic [ADDR_W-1:0] rd);
        bus.iss_valid = 1'b1;
        bus.iss_rd    = rd;
        step();
        bus.iss_valid = 1'b0;
    endtask

    task automatic write_alu(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] data);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = rd;
        bus.alu_data  = data;
        step();
        bus.alu_valid = 1'b0;
    endtask

    task automatic write_mem(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] data);
        bus.mem_valid = 1'b1;
        bus.mem_rd    = rd;
        bus.mem_data  = data;
        step();
        bus.mem_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_rd = '0; bus.mem_data = '0;
        bus.iss_rd = '0; bus.rs = '0; bus.rt = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // single ALU write to r5
        bus.rs = 5'd5;
        issue_once(5'd5);
        write_alu(5'd5, 32'hDEAD_BEEF);
        repeat (2) step();

        // contended requests, losers hold until granted
        for (int r = 1; r <= 4; r++) begin
            issue_once(5'(r));
            issue_once(5'(r + 10));
        end
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'hA000_0001;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd11; bus.mem_data = 32'hB000_0011;
        for (int k = 0; k < 4; k++) begin
            step();
            if (ga_m) begin bus.alu_rd = bus.alu_rd + 5'd1; bus.alu_data = bus.alu_data + 32'd1; end
            if (gm_m) begin bus.mem_rd = bus.mem_rd + 5'd1; bus.mem_data = bus.mem_data + 32'd1; end
        end
        idle();
        repeat (2) step();

        // saturate r7, then drain it
        bus.rt = 5'd7;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
        repeat (4) step();
        bus.iss_valid = 1'b0;
        write_mem(5'd7, 32'h7777_0001);
        repeat (3) step();
        write_mem(5'd7, 32'h7777_0002);
        write_mem(5'd7, 32'h7777_0003);
        repeat (2) step();

        // issue and retire r9 in the same cycle
        bus.rs = 5'd9;
        issue_once(5'd9);
        write_mem(5'd9, 32'h9999_0001);
        issue_once(5'd9);
        repeat (2) step();
        write_mem(5'd9, 32'h9999_0002);
        repeat (2) step();

        // r0 write is dropped; r20 write with nothing pending is an underflow
        write_alu(5'd0, 32'h0000_1234);
        step();
        write_alu(5'd20, 32'h2020_2020);
        repeat (3) step();

        // asynchronous reset while a write is in flight
        bus.rs = 5'd3;
        issue_once(5'd3);
        write_alu(5'd3, 32'h3333_3333);
        chk("pre_rst_rf_en", bus.rf_en, 1'b1);
        chk("pre_rst_sb_err", bus.sb_err, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("async_rf_en", bus.rf_en, 1'b0);
        chk("async_rs_busy", bus.rs_busy, 1'b0);
        chk("async_sb_err", bus.sb_err, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        step();

        // random traffic over a small register window to provoke hazards
        for (int c = 0; c < 1200; c++) begin
            if (c == 600) begin
                idle();
                #2 rst = 1'b0;
                @(posedge clk);
                #1 rst = 1'b1;
            end
            if (!bus.alu_valid || ga_m) begin
                bus.alu_valid = ($urandom_range(0, 3) == 0);
                bus.alu_rd    = 5'($urandom_range(0, 7));
                bus.alu_data  = $urandom;
            end
            if (!bus.mem_valid || gm_m) begin
                bus.mem_valid = ($urandom_range(0, 3) == 0);
                bus.mem_rd    = 5'($urandom_range(0, 7));
                bus.mem_data  = $urandom;
            end
            bus.iss_valid = ($urandom_range(0, 1) == 0);
            bus.iss_rd    = 5'($urandom_range(0, 7));
            bus.rs        = 5'($urandom_range(0, 7));
            bus.rt        = 5'($urandom_range(0, 7));
            step();
        end
        idle();
        repeat (3) step();
        chk("pending_writes", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Sequences the single write port (`en`, `rd`, `data`) of the core's `register_file` and shares it between two writeback requesters: the ALU result path and the memory-load path. Each write consumes one port slot. A per-register pending-write scoreboard lets the issue stage detect RAW hazards on the `rs`/`rt` read ports. The block sits between the execute/memory stages and `register_file`; its `rf_*` outputs connect directly to that module's `en`/`rd`/`data` inputs.

## Interface
Parameters:
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register index width; the file holds 2^ADDR_W registers
- `CNT_W`, 2, width of each pending-write counter

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `alu_valid`  in  1  ALU write request
- `alu_ready`  out  1  ALU request granted this cycle
- `alu_rd`  in  ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU write data
- `mem_valid`, `mem_ready`, `mem_rd`, `mem_data`: same as the ALU ports, for the load path
- `iss_valid`  in  1  issue stage marks `iss_rd` as pending
- `iss_ready`  out  1  pending counter for `iss_rd` is not saturated
- `iss_rd`  in  ADDR_W  register being issued
- `rs`, `rt`  in  ADDR_W  read indices, shared with the register file
- `rs_busy`, `rt_busy`  out  1  indexed register has a pending write
- `rf_en`  out  1  to `register_file.en`
- `rf_rd`  out  ADDR_W  to `register_file.rd`
- `rf_data`  out  DATA_W  to `register_file.data`
- `sb_err`  out  1  sticky scoreboard underflow flag

## Operation
- Handshake: a request completes in any cycle where `x_valid & x_ready`. `x_ready` is combinational and is at most one-hot.
- Arbitration:
  - A single requester is granted immediately.
  - When both request, the priority bit `pri` picks the winner (0 = ALU, 1 = MEM). `pri` then toggles to favour the loser.
  - `pri` changes only on contended grants.
  - Worst-case wait is one grant.
- Write stage: the accepted request is registered into `rf_en`/`rf_rd`/`rf_data`. If no request is accepted, `rf_en` is 0 next cycle and `rf_rd`/`rf_data` hold their values.
- Writes to register 0: the handshake completes, but `rf_en` stays 0 (the write is dropped).
- Scoreboard: one CNT_W-bit counter per register, index 0 never counted.
  - Increment on `iss_valid & iss_ready & iss_rd != 0`.
  - Decrement on `rf_en` for `rf_rd`.
  - Increment and decrement of the same register in one cycle leave the counter unchanged.
  - `iss_ready` = 0 while `cnt[iss_rd]` = 2^CNT_W−1 (saturated).
  - A decrement at count 0 holds the counter at 0 and sets `sb_err` until reset.
- `rs_busy` = `cnt[rs] != 0` and `rt_busy` = `cnt[rt] != 0`, both combinational. Index 0 always reads not busy.

## Timing
- Reset values: `rf_en` 0, `rf_rd` 0, `rf_data` 0, `pri` 0, all counters 0, `sb_err` 0. Combinational outputs follow from this state.
- A request accepted in cycle N produces `rf_en` = 1 in cycle N+1. The register file stores the data at the end of N+1.
- The counter decrements at the same edge as the register file write. `busy` clears, and the new data is readable, from N+2.
- An issue in cycle N makes `busy` visible from N+1.
- Back-to-back grants sustain one write per cycle with no bubbles.
- Reset asserted mid-operation:
  - In-flight `rf_en` is cleared immediately, so the pending write is lost.
  - Counters clear, and requesters must re-present their requests after reset.

## Structure
- Shared header/package `lapido_rf_defs`: `DATA_W`, `ADDR_W`, `NREGS`, `CNT_W`, and the source encodings `SRC_ALU` = 0 and `SRC_MEM` = 1. The register file and this block both use it.
- One sub-module, `regfile_scoreboard`. It holds the counter array, the inc/dec/saturation logic, the two busy lookups, `iss_ready` and `sb_err`. The top level holds the arbiter and the write-stage register.

## Test plan
- Reset, then a single ALU write `rd` = 5, data 0xDEADBEEF in cycle N → `alu_ready` = 1 in N; `rf_en` = 1 with `rf_rd` = 5 in N+1; `register_file` r5 = 0xDEADBEEF in N+2.
- ALU and MEM both valid for 4 cycles (ALU→r1..r4, MEM→r11..r14) → grants go ALU, MEM, ALU, MEM; `rf_rd` sequence 1, 11, 2, 12; each loser stays valid until granted.
- Issue r7 three times → `iss_ready` = 0 on the fourth attempt. One MEM write to r7 → `rt_busy` (`rt` = 7) stays 1 and the counter reads 2. Two more writes → `rt_busy` = 0.
- In one cycle, issue r9 while `rf_en` writes r9 with count 1 → count stays 1 and `rs_busy` = 1.
- ALU write to r0 with data 0x1234 → `alu_ready` = 1, `rf_en` stays 0, r0 unchanged. A write to r20 with no pending issue → `sb_err` = 1 and stays set.
- Assert `rst` low while `rf_en` = 1 → `rf_en`, `pri`, all busy outputs and `sb_err` go to 0 before the next edge, and the register file is not written.
